// File: rtl/mult_reg_unit_if.sv
// Strobe/operand bundle between the multiplier control FSM (master) and the datapath (slave).
// MULT_SHIFT_CNT_EN adds the ShiftCnt debug count to the bundle.
interface mult_reg_unit_if #(
    parameter int WIDTH = 8
);
    logic             Clr_Ld;
    logic             clearA;
    logic             Add;
    logic             Sub;
    logic             Shift;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             X;
    logic             M;
`ifdef MULT_SHIFT_CNT_EN
    logic [$clog2(WIDTH+1)-1:0] ShiftCnt;

    modport master (
        output Clr_Ld, clearA, Add, Sub, Shift, S,
        input  Aval, Bval, X, M, ShiftCnt
    );
    modport slave (
        input  Clr_Ld, clearA, Add, Sub, Shift, S,
        output Aval, Bval, X, M, ShiftCnt
    );
`else
    modport master (
        output Clr_Ld, clearA, Add, Sub, Shift, S,
        input  Aval, Bval, X, M
    );
    modport slave (
        input  Clr_Ld, clearA, Add, Sub, Shift, S,
        output Aval, Bval, X, M
    );
`endif
endinterface

// File: rtl/mult_reg_unit.sv
// Datapath of the signed add-shift multiplier: sign bit X, accumulator A, multiplier B.
// Optional feature MULT_SHIFT_CNT_EN: saturating count of accepted shifts on ShiftCnt.
module mult_reg_unit #(
    parameter int WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    mult_reg_unit_if.slave bus
);
    localparam logic signed [WIDTH:0] L_ONE = (WIDTH+1)'(1);

    logic             r_x;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic signed [WIDTH:0] w_a_ext;
    logic signed [WIDTH:0] w_s_ext;
    logic signed [WIDTH:0] w_sum;
    logic signed [WIDTH:0] w_dif;
    logic                  w_arith;
    logic                  w_shift_acc;

    // Both operands are sign-extended to WIDTH+1 bits so X is always the true sign.
    assign w_a_ext = signed'({r_a[WIDTH-1], r_a});
    assign w_s_ext = signed'({bus.S[WIDTH-1], bus.S});
    assign w_sum   = w_a_ext + w_s_ext;
    assign w_dif   = w_a_ext + ~w_s_ext + L_ONE;

    // Add and Sub together is illegal: it still blocks a shift in that cycle, but writes nothing.
    assign w_arith     = bus.Add | bus.Sub;
    assign w_shift_acc = bus.Shift & ~w_arith & ~bus.clearA & ~bus.Clr_Ld;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x <= 1'b0;
            r_a <= '0;
            r_b <= '0;
        end else if (bus.Clr_Ld) begin
            r_x <= 1'b0;
            r_a <= '0;
            r_b <= bus.S;
        end else if (bus.clearA) begin
            r_x <= 1'b0;
            r_a <= '0;
        end else if (w_arith) begin
            if (bus.Add && !bus.Sub) begin
                {r_x, r_a} <= w_sum;
            end else if (bus.Sub && !bus.Add) begin
                {r_x, r_a} <= w_dif;
            end
        end else if (bus.Shift) begin
            r_a <= {r_x, r_a[WIDTH-1:1]};
            r_b <= {r_a[0], r_b[WIDTH-1:1]};
        end
    end

    assign bus.Aval = r_a;
    assign bus.Bval = r_b;
    assign bus.X    = r_x;
    assign bus.M    = r_b[0];

`ifdef MULT_SHIFT_CNT_EN
    localparam int CW = $clog2(WIDTH+1);

    logic [CW-1:0] r_cnt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(WIDTH)) ? c : c + CW'(1);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset || bus.Clr_Ld || bus.clearA) begin
            r_cnt <= '0;
        end else if (w_shift_acc) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign bus.ShiftCnt = r_cnt;
`else
    logic w_unused;
    assign w_unused = w_shift_acc;
`endif
endmodule

// File: tb/tb_mult_reg_unit.sv
// Self-checking bench for mult_reg_unit: directed cases plus a randomized strobe walk
// against an integer-arithmetic model. Define MULT_SHIFT_CNT_EN to also check ShiftCnt.
module tb_mult_reg_unit;
    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mult_reg_unit_if #(.WIDTH(W)) bus ();
    mult_reg_unit #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Model state: sign bit, A, B as plain integers, plus accepted-shift count.
    int m_x, m_a, m_b, m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit cl, input bit ca, input bit ad,
                              input bit sb, input bit sh, input int s);
        int sv, av, r, f;
        sv = (s >= 128) ? s - 256 : s;
        av = (m_a >= 128) ? m_a - 256 : m_a;
        if (rst) begin
            m_x = 0; m_a = 0; m_b = 0; m_cnt = 0;
        end else if (cl) begin
            m_x = 0; m_a = 0; m_b = s; m_cnt = 0;
        end else if (ca) begin
            m_x = 0; m_a = 0; m_cnt = 0;
        end else if (ad || sb) begin
            if (!(ad && sb)) begin
                r   = ad ? av + sv : av - sv;
                m_x = (r < 0) ? 1 : 0;
                m_a = r & 255;
            end
        end else if (sh) begin
            f   = (m_x != 0 ? -65536 : 0) + m_a * 256 + m_b;
            f   = f >>> 1;
            m_a = (f >> 8) & 255;
            m_b = f & 255;
            if (m_cnt < W) m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".A"}, 32'(bus.Aval), 32'(m_a));
        check_val({tag, ".B"}, 32'(bus.Bval), 32'(m_b));
        check_val({tag, ".X"}, 32'(bus.X), 32'(m_x));
        check_val({tag, ".M"}, 32'(bus.M), 32'(m_b & 1));
`ifdef MULT_SHIFT_CNT_EN
        check_val({tag, ".CNT"}, 32'(bus.ShiftCnt), 32'(m_cnt));
`endif
    endtask

    task automatic step(input bit rst, input bit cl, input bit ca, input bit ad,
                        input bit sb, input bit sh, input logic [7:0] s, input string tag);
        Reset      = rst;
        bus.Clr_Ld = cl;
        bus.clearA = ca;
        bus.Add    = ad;
        bus.Sub    = sb;
        bus.Shift  = sh;
        bus.S      = s;
        @(posedge Clk);
        model_step(rst, cl, ca, ad, sb, sh, int'(s));
        #1;
        check_all(tag);
    endtask

    initial begin
        m_x = 0; m_a = 0; m_b = 0; m_cnt = 0;
        step(1, 0, 0, 0, 0, 0, 8'h00, "init");

        // Scramble state, then reset
        for (int i = 0; i < 12; i++)
            step(0, (i == 0), 0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 8'($urandom), "scr");
        step(1, 0, 0, 0, 0, 0, 8'($urandom), "rst");
        check_val("rst.A0", 32'(bus.Aval), 32'h00);
        check_val("rst.B0", 32'(bus.Bval), 32'h00);
        check_val("rst.X0", 32'(bus.X), 32'h0);
        check_val("rst.M0", 32'(bus.M), 32'h0);

        step(0, 1, 0, 0, 0, 0, 8'hFD, "clrld");
        check_val("clrld.B", 32'(bus.Bval), 32'hFD);
        check_val("clrld.M", 32'(bus.M), 32'h1);

        step(0, 0, 0, 1, 0, 0, 8'h07, "add7");
        check_val("add7.A", 32'(bus.Aval), 32'h07);
        step(0, 0, 0, 0, 1, 0, 8'h07, "sub7a");
        check_val("sub7a.A", 32'(bus.Aval), 32'h00);
        step(0, 0, 0, 0, 1, 0, 8'h07, "sub7b");
        check_val("sub7b.A", 32'(bus.Aval), 32'hF9);
        check_val("sub7b.X", 32'(bus.X), 32'h1);
        step(0, 0, 0, 0, 0, 1, 8'h55, "shf");
        check_val("shf.A", 32'(bus.Aval), 32'hFC);
        check_val("shf.B", 32'(bus.Bval), 32'hFE);
        check_val("shf.X", 32'(bus.X), 32'h1);

        // Full multiply -3 * 7
        step(0, 1, 0, 0, 0, 0, 8'hFD, "run.ld");
        for (int p = 0; p < 8; p++) begin
            if ((m_b & 1) != 0)
                step(0, 0, 0, (p < 7), (p == 7), 0, 8'h07, "run.op");
            step(0, 0, 0, 0, 0, 1, 8'($urandom), "run.sh");
        end
        check_val("run.prod", {16'h0, bus.Aval, bus.Bval}, 32'hFFEB);
`ifdef MULT_SHIFT_CNT_EN
        check_val("run.cnt8", 32'(bus.ShiftCnt), 32'd8);
`endif

        // Sign bit does not wrap: 0x7F + 0x01
        step(0, 0, 1, 0, 0, 0, 8'h00, "ca");
        step(0, 0, 0, 1, 0, 0, 8'h7F, "p7f");
        step(0, 0, 0, 1, 0, 0, 8'h01, "p01");
        check_val("ovf.A", 32'(bus.Aval), 32'h80);
        check_val("ovf.X", 32'(bus.X), 32'h0);

        // Illegal Add+Sub holds, arithmetic beats shift, reset clears mid-run
        step(0, 1, 0, 0, 0, 0, 8'hA5, "ill.ld");
        step(0, 0, 0, 1, 0, 0, 8'h33, "ill.add");
        step(0, 0, 0, 1, 1, 1, 8'h12, "ill.both");
        check_val("ill.A", 32'(bus.Aval), 32'h33);
        check_val("ill.B", 32'(bus.Bval), 32'hA5);
        step(0, 0, 0, 1, 0, 1, 8'h01, "ari.sh");
        check_val("arish.A", 32'(bus.Aval), 32'h34);
        check_val("arish.B", 32'(bus.Bval), 32'hA5);
        step(1, 0, 0, 1, 0, 1, 8'h01, "mid.rst");
        check_val("midrst.AB", {16'h0, bus.Aval, bus.Bval}, 32'h0);

        // Shift count saturation
        step(0, 0, 1, 0, 0, 0, 8'h00, "sat.ca");
        for (int i = 0; i < 11; i++)
            step(0, 0, 0, 0, 0, 1, 8'($urandom), "sat.sh");
`ifdef MULT_SHIFT_CNT_EN
        check_val("sat.cnt", 32'(bus.ShiftCnt), 32'd8);
`endif

        // Randomized strobe walk
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 14) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                 8'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
